// File: rtl/mem_stage_cache_if.sv
// ---------------------------------------------------------------------------
// MemStageCacheIf
// Bundles every signal between the MEM-stage data cache, the pipeline and
// main memory.
//   Pipeline -> cache : cache_en, mem_write, is_LB_SB, address, write_data
//   Cache -> pipeline : cache_data_out, mem_block, freeze
//   Cache -> memory   : mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
//   Memory -> cache   : mem_rdata, mem_ready
// The cache controller connects through the slave modport. The master
// modport is the view of whoever drives the pipeline and memory side.
// ---------------------------------------------------------------------------
interface mem_stage_cache_if;
    logic        cache_en;
    logic        mem_write;
    logic        is_LB_SB;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] cache_data_out;
    logic [1:0]  mem_block;
    logic        freeze;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  cache_en, mem_write, is_LB_SB, address, write_data,
        input  mem_rdata, mem_ready,
        output cache_data_out, mem_block, freeze,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output cache_en, mem_write, is_LB_SB, address, write_data,
        output mem_rdata, mem_ready,
        input  cache_data_out, mem_block, freeze,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_stage_cache.sv
// ---------------------------------------------------------------------------
// mem_stage_cache
// Data-side cache controller for the MEM stage. The cache is direct-mapped,
// holds one 32-bit word per line, and is write-through with no write
// allocate. It supports word and byte (LB/SB) accesses. Load hits return
// data in the same cycle. Load misses and all stores stall the pipeline
// through freeze while a req/ready transfer to main memory completes.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - MemStageCacheIf slave modport (pipeline side and memory side)
// Parameter:
//   INDEX_BITS - number of line-index bits (2**INDEX_BITS lines)
// ---------------------------------------------------------------------------
module mem_stage_cache #(
    parameter int INDEX_BITS = 5
) (
    input  logic           clk,
    input  logic           rst,
    mem_stage_cache_if.slave bus
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - 2;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_MISS = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                doneFlag_q, doneFlag_d;
    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tagArray_q  [LINES];
    logic [31:0]         dataArray_q [LINES];

    logic [1:0]            offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic [31:0]           lineData;
    logic                  hit;
    logic                  freezeRaw;
    logic                  refillDone;
    logic                  writeDone;
    logic [31:0]           storeWdata;
    logic [3:0]            storeWstrb;
    logic [31:0]           mergedWord;

    assign offset   = bus.address[1:0];
    assign index    = bus.address[INDEX_BITS+1:2];
    assign tag      = bus.address[31:INDEX_BITS+2];
    assign lineData = dataArray_q[index];
    assign hit      = valid_q[index] && (tagArray_q[index] == tag);

    assign refillDone = (state_q == RD_MISS) && bus.mem_ready;
    assign writeDone  = (state_q == WRITE) && bus.mem_ready;

    // Store data as it goes out to memory. A byte store replicates the byte
    // on every lane so memory only has to honour the strobes.
    always_comb begin
        storeWdata = bus.write_data;
        storeWstrb = 4'hF;
        if (bus.is_LB_SB) begin
            storeWdata = {4{bus.write_data[7:0]}};
            storeWstrb = 4'b0001 << offset;
        end
    end

    // The cached word after a store hit. It takes only the strobed lanes,
    // so the same merge covers both SW and SB.
    always_comb begin
        mergedWord = lineData;
        for (int lane = 0; lane < 4; lane++) begin
            if (storeWstrb[lane]) begin
                mergedWord[lane*8 +: 8] = storeWdata[lane*8 +: 8];
            end
        end
    end

    // Next-state and freeze logic. The done flag covers the IDLE cycle right
    // after a completed transfer. The pipeline still presents the same
    // instruction in that cycle, so it must not be treated as a new access.
    // The flag stays set only while freeze is high. The first unfrozen edge
    // clears it, so back-to-back accesses after that proceed normally.
    always_comb begin
        state_d   = state_q;
        freezeRaw = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cache_en && !doneFlag_q) begin
                    if (bus.mem_write) begin
                        freezeRaw = 1'b1;
                        state_d   = WRITE;
                    end else if (!hit) begin
                        freezeRaw = 1'b1;
                        state_d   = RD_MISS;
                    end
                end
            end
            RD_MISS, WRITE: begin
                freezeRaw = 1'b1;
                if (bus.mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        doneFlag_d = (refillDone || writeDone) ? 1'b1
                   : (freezeRaw ? doneFlag_q : 1'b0);
    end

    // Pipeline and memory outputs. Reset forces everything quiet, even
    // while rst is high in the middle of a transfer.
    assign bus.freeze         = freezeRaw && !rst;
    assign bus.mem_req        = (state_q != IDLE) && !rst;
    assign bus.mem_we         = (state_q == WRITE) && !rst;
    assign bus.cache_data_out = (!rst && state_q == IDLE && bus.cache_en
                                 && !bus.mem_write && hit) ? lineData : 32'd0;
    assign bus.mem_block      = offset;
    assign bus.mem_addr       = {bus.address[31:2], 2'b00};
    assign bus.mem_wdata      = storeWdata;
    assign bus.mem_wstrb      = storeWstrb;

    // Controller state and valid bits. Reset abandons any transfer in
    // flight. A late mem_ready then finds the controller in IDLE, where it
    // is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            doneFlag_q <= 1'b0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            doneFlag_q <= doneFlag_d;
            if (refillDone) begin
                valid_q[index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays have no reset, because the valid bits alone make
    // stale contents harmless. The arrays do not change while a store waits
    // in WRITE, so the hit seen at completion is the hit seen at issue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (refillDone) begin
                tagArray_q[index]  <= tag;
                dataArray_q[index] <= bus.mem_rdata;
            end else if (writeDone && hit) begin
                dataArray_q[index] <= mergedWord;
            end
        end
    end

endmodule

// File: doc/mem_stage_cache.md
Name: mem_stage_cache

Overview:
- Data-side cache controller for the MEM stage.
- Produces the values the MEM/WB pipeline register captures: cache_data_out, mem_block, and the pipeline freeze.
- Direct-mapped cache, one 32-bit word per line, write-through, no-write-allocate. Supports word and byte (LB/SB) accesses.
- Talks to main memory over a req/ready handshake with arbitrary latency.

Parameters:
- INDEX_BITS, 5, number of line-index bits; the cache holds 2**INDEX_BITS lines.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- cache_en  input  1  MEM-stage instruction performs a memory access.
- mem_write  input  1  access is a store (1) or load (0).
- is_LB_SB  input  1  byte access (1) or word access (0).
- address  input  32  byte address (ALU result).
- write_data  input  32  store data (rt_data); for SB, bits 7:0 are used.
- cache_data_out  output  32  full word read for a load hit.
- mem_block  output  2  byte offset address[1:0], forwarded for WB byte select.
- freeze  output  1  stall request to all pipeline registers.
- mem_req  output  1  main-memory request.
- mem_we  output  1  request is a write.
- mem_addr  output  32  word-aligned address, {address[31:2],2'b00}.
- mem_wdata  output  32  write data; for SB, byte replicated on all lanes.
- mem_wstrb  output  4  byte enables; 4'hF for SW, one-hot by address[1:0] for SB.
- mem_rdata  input  32  read data, valid when mem_ready=1.
- mem_ready  input  1  single-cycle completion pulse.

Behaviour:
- Address split: offset = address[1:0]; index = address[INDEX_BITS+1:2]; tag = address[31:INDEX_BITS+2].
- Each line holds a valid bit, a tag and a 32-bit data word.
- Byte lanes are little-endian: lane 0 = bits 7:0.
- Hit: valid[index] && tag match.
- Reset (rst=1 at posedge):
  - all valid bits cleared; state=IDLE.
  - mem_req=0, mem_we=0.
  - freeze=0, cache_data_out=0.
  - Data and tag arrays are not cleared.
  - A reset during RD_MISS or WRITE abandons the transfer; mem_ready arriving after reset is ignored.
- Outputs in IDLE are combinational; registered state changes only on posedge.
- FSM states: IDLE, RD_MISS, WRITE.
- IDLE:
  - cache_en=0: freeze=0, cache_data_out=0, mem_req=0.
  - Load hit: cache_data_out=line data the same cycle; freeze=0; zero-cycle latency.
  - Load miss: freeze=1 the same cycle; next state RD_MISS.
  - Any store, hit or miss: freeze=1 the same cycle; next state WRITE.
- RD_MISS:
  - mem_req=1, mem_we=0; freeze=1, including the mem_ready cycle.
  - On mem_ready: line written (valid=1, tag, data=mem_rdata); state→IDLE.
  - The following IDLE cycle hits: freeze=0, data delivered.
  - Minimum load-miss stall is 2 cycles, i.e. mem_ready on the first RD_MISS cycle.
- WRITE:
  - mem_req=1, mem_we=1, mem_wdata/mem_wstrb as above; freeze=1, including the mem_ready cycle.
  - On mem_ready, if the line hit at store time: data updated; whole word for SW, only the selected byte lane for SB. Valid and tag unchanged.
  - On mem_ready, if the store missed: cache unchanged (no allocate).
  - Then state→IDLE; the next cycle sees the same store inputs. The controller must not re-issue it, so an internal done flag, set on WRITE completion, forces freeze=0 and no new request for that cycle. The flag is cleared at the next posedge where freeze=0.
- The same done-flag rule holds for loads; the refilled line makes them hit anyway.
- Inputs are held stable by the pipeline while freeze=1; the controller samples them continuously.
- mem_req stays high from state entry until the mem_ready cycle inclusive; it deasserts the cycle after.
- mem_ready outside RD_MISS/WRITE is ignored.
- Word access ignores address[1:0] for the cache lookup. Misaligned SW is written as an aligned word.
- Back-to-back accesses are allowed: an access in the IDLE cycle immediately after a completion (with the done flag clear) is handled normally.

Test Plan:
- After reset, LW 0x0000_0040, memory returns 0xDEAD_BEEF after 3 cycles → freeze high 4 cycles then low; cache_data_out=0xDEADBEEF; mem_block=0; exactly one mem_req burst.
- Repeat LW 0x40 → hit: freeze=0, cache_data_out=0xDEADBEEF same cycle, mem_req stays 0.
- SB 0x43 data 0x11 on cached line → mem_wstrb=4'b1000, mem_wdata=0x11111111; then LW 0x40 hits with 0x11ADBEEF.
- SW 0x0000_0080 (not cached), then LW 0x80 → store completes without allocating; load misses and issues a read request.
- LW 0x0000_0040 then LW 0x0000_00C0, both index 16, different tags → second misses and evicts; LW 0x40 misses again.
- Assert rst during RD_MISS before mem_ready → next cycle mem_req=0, freeze=0; LW 0x40 then misses (valid cleared); a stray mem_ready is ignored.
